// File: rtl/symbol_rx_pkg.sv
// symbol_rx shared types and frame constants.
// Parity support is selected by SYMBOL_RX_PARITY_EN.
package symbol_rx_pkg;

`ifdef SYMBOL_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;
`endif

  // start + parity + stop
  localparam int unsigned OVH_BITS_PAR   = 3;
  // start + stop
  localparam int unsigned OVH_BITS_NOPAR = 2;
  // payload plus parity bit must hold an odd number of ones
  localparam logic        PAR_ODD        = 1'b1;

  function automatic int unsigned frame_bits(input int unsigned dw);
`ifdef SYMBOL_RX_PARITY_EN
    return dw + OVH_BITS_PAR;
`else
    return dw + OVH_BITS_NOPAR;
`endif
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // count up to all-ones and hold there; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/symbol_rx.sv
// Strobed serial symbol receiver, MSB first, with error counter.
// Define SYMBOL_RX_PARITY_EN to add an odd-parity bit to each frame.
module symbol_rx
  import symbol_rx_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_i,
  input  logic              bit_en_i,
  input  logic              clr_err_i,
  output logic [DATA_W-1:0] code_o,
  output logic              code_valid_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic [ERR_W-1:0]  err_cnt_o
);

  localparam int CNT_W = $clog2(frame_bits(DATA_W));

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_sh;
  logic [DATA_W-1:0]  r_code;
  logic               r_valid;
  logic               r_perr;
  logic               r_ferr;
  logic               w_last;
  logic               w_ok;
  logic               w_stop;
  logic               w_accept;
  logic               w_perr;
  logic               w_ferr;

`ifdef SYMBOL_RX_PARITY_EN
  logic               r_par_ok;
  assign w_ok = r_par_ok;
`else
  assign w_ok = 1'b1;
`endif

  assign w_last = (r_cnt == CNT_W'(DATA_W - 1));

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state; only strobed cycles move the FSM
  always_comb begin
    w_next = r_state;
    if (bit_en_i) begin
      unique case (r_state)
        S_IDLE: begin
          if (!rx_i) w_next = S_DATA;
        end
        S_DATA: begin
`ifdef SYMBOL_RX_PARITY_EN
          if (w_last) w_next = S_PARITY;
`else
          if (w_last) w_next = S_STOP;
`endif
        end
`ifdef SYMBOL_RX_PARITY_EN
        S_PARITY: w_next = S_STOP;
`endif
        S_STOP:   w_next = rx_i ? S_IDLE : S_BREAK;
        S_BREAK: begin
          if (rx_i) w_next = S_IDLE;
        end
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // stop-bit outcome; a framing error masks a parity error
  always_comb begin
    w_stop   = bit_en_i && (r_state == S_STOP);
    w_accept = w_stop && rx_i && w_ok;
    w_ferr   = w_stop && !rx_i;
`ifdef SYMBOL_RX_PARITY_EN
    w_perr   = w_stop && rx_i && !w_ok;
`else
    w_perr   = 1'b0;
`endif
  end

  // shift path, parity latch and registered result pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_sh     <= '0;
      r_code   <= '0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
`ifdef SYMBOL_RX_PARITY_EN
      r_par_ok <= 1'b0;
`endif
    end else begin
      r_valid <= w_accept;
      r_perr  <= w_perr;
      r_ferr  <= w_ferr;
      if (w_accept) r_code <= r_sh;
      if (bit_en_i) begin
        if (r_state == S_IDLE) begin
          r_cnt <= '0;
        end
        if (r_state == S_DATA) begin
          r_sh  <= {r_sh[DATA_W-2:0], rx_i};
          r_cnt <= r_cnt + CNT_W'(1);
        end
`ifdef SYMBOL_RX_PARITY_EN
        if (r_state == S_PARITY) begin
          r_par_ok <= ((^r_sh) ^ rx_i) == PAR_ODD;
        end
`endif
      end
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (r_perr | r_ferr),
    .i_clr (clr_err_i),
    .o_cnt (err_cnt_o)
  );

  assign code_o       = r_code;
  assign code_valid_o = r_valid;
  assign parity_err_o = r_perr;
  assign frame_err_o  = r_ferr;

endmodule

// File: tb/tb_symbol_rx.sv
// Self-checking bench for symbol_rx: frame-level model plus
// directed literal expectations; works with or without parity.
module tb_symbol_rx;

  localparam int DW  = 7;
  localparam int EW  = 4;
  localparam int SAT = (1 << EW) - 1;
`ifdef SYMBOL_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          rx_i      = 1'b1;
  logic          bit_en_i  = 1'b0;
  logic          clr_err_i = 1'b0;
  logic [DW-1:0] code_o;
  logic          code_valid_o;
  logic          parity_err_o;
  logic          frame_err_o;
  logic [EW-1:0] err_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  symbol_rx #(
    .DATA_W (DW),
    .ERR_W  (EW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_i         (rx_i),
    .bit_en_i     (bit_en_i),
    .clr_err_i    (clr_err_i),
    .code_o       (code_o),
    .code_valid_o (code_valid_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  // frame-level model: 0 idle, 1 collecting bits, 2 await stop, 3 break
  int            m_mode = 0;
  int            m_bits[$];
  logic [DW-1:0] m_code = '0;
  logic          m_v    = 1'b0;
  logic          m_pe   = 1'b0;
  logic          m_fe   = 1'b0;
  int            m_err  = 0;

  task automatic model_sample(input logic b);
    int            ones;
    logic [DW-1:0] pay;
    case (m_mode)
      0: if (!b) begin
        m_mode = 1;
        m_bits.delete();
      end
      1: begin
        m_bits.push_back(int'(b));
        if (m_bits.size() == DW + PB) m_mode = 2;
      end
      2: begin
        if (!b) begin
          m_fe   = 1'b1;
          m_mode = 3;
        end else begin
          ones = 0;
          pay  = '0;
          for (int i = 0; i < DW; i++) pay = {pay[DW-2:0], 1'(m_bits[i])};
          foreach (m_bits[i]) ones += m_bits[i];
          if (PB == 0 || (ones % 2) == 1) begin
            m_code = pay;
            m_v    = 1'b1;
          end else begin
            m_pe = 1'b1;
          end
          m_mode = 0;
        end
      end
      default: if (b) m_mode = 0;
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0;
      m_bits.delete();
      m_code = '0;
      m_v    = 1'b0;
      m_pe   = 1'b0;
      m_fe   = 1'b0;
      m_err  = 0;
    end else begin
      if (clr_err_i) m_err = 0;
      else if ((m_pe || m_fe) && m_err < SAT) m_err++;
      m_v  = 1'b0;
      m_pe = 1'b0;
      m_fe = 1'b0;
      if (bit_en_i) model_sample(rx_i);
    end
  end

  always @(negedge clk) begin
    check("cycle",
      int'({code_o, code_valid_o, parity_err_o, frame_err_o, err_cnt_o}),
      int'({m_code, m_v, m_pe, m_fe, EW'(m_err)}));
  end

  task automatic strobe(input logic b, input int gap);
    rx_i     = b;
    bit_en_i = 1'b1;
    @(posedge clk) #1;
    bit_en_i = 1'b0;
    repeat (gap) begin
      rx_i = 1'($urandom);
      @(posedge clk) #1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p,
                            input logic stp, input int maxg);
    strobe(1'b0, int'($urandom_range(maxg, 0)));
    for (int i = DW - 1; i >= 0; i--)
      strobe(d[i], int'($urandom_range(maxg, 0)));
`ifdef SYMBOL_RX_PARITY_EN
    strobe(p, int'($urandom_range(maxg, 0)));
`else
    if (p === 1'bx) $display("parity bit unknown");
`endif
    strobe(stp, 0);
  endtask

  initial begin
    @(negedge clk);
    check("rst_code", int'(code_o), 0);
    check("rst_err", int'(err_cnt_o), 0);
    @(posedge clk) #1;
    reset = 1'b1;
    strobe(1'b1, 1);
    strobe(1'b1, 0);

    send_frame(7'b1011000, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("good_valid", int'(code_valid_o), 1);
    check("good_code", int'(code_o), 'b1011000);
    @(negedge clk);
    check("good_width", int'(code_valid_o), 0);
    @(posedge clk) #1;

    send_frame(7'b0101000, 1'b0, 1'b1, 0);
    strobe(1'b1, 1);
`ifdef SYMBOL_RX_PARITY_EN
    check("badpar_code", int'(code_o), 'b1011000);
    check("badpar_err", int'(err_cnt_o), 1);
`else
    check("nopar_code", int'(code_o), 'b0101000);
    check("nopar_err", int'(err_cnt_o), 0);
`endif

    send_frame(7'b1101011, 1'b0, 1'b0, 0);
    repeat (3) strobe(1'b0, 1);
    strobe(1'b1, 0);
    send_frame(7'b0001100, 1'b1, 1'b1, 0);
    strobe(1'b1, 1);
    check("brk_code", int'(code_o), 'b0001100);
    check("brk_err", int'(err_cnt_o), 1 + PB);

    clr_err_i = 1'b1;
    @(posedge clk) #1;
    clr_err_i = 1'b0;
    repeat (17) begin
      send_frame(7'b0000001, 1'b1, 1'b0, 0);
      strobe(1'b1, 0);
    end
    strobe(1'b1, 1);
    check("sat_err", int'(err_cnt_o), 15);
    send_frame(7'b0000001, 1'b1, 1'b0, 0);
    check("clr_pulse", int'(frame_err_o), 1);
    clr_err_i = 1'b1;
    strobe(1'b1, 0);
    clr_err_i = 1'b0;
    strobe(1'b1, 1);
    check("clr_win", int'(err_cnt_o), 0);

    strobe(1'b0, 0);
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    strobe(1'b0, 0);
    reset = 1'b0;
    @(posedge clk) #1;
    reset = 1'b1;
    check("rst_mid_code", int'(code_o), 0);
    send_frame(7'b0100011, 1'b0, 1'b1, 0);
    strobe(1'b1, 1);
    check("rst_new_code", int'(code_o), 'b0100011);

    send_frame(7'b1011000, 1'b0, 1'b1, 5);
    @(negedge clk);
    check("gap_valid", int'(code_valid_o), 1);
    check("gap_code", int'(code_o), 'b1011000);
    @(negedge clk);
    check("gap_width", int'(code_valid_o), 0);
    @(posedge clk) #1;
    send_frame(7'b0110010, 1'b0, 1'b1, 5);
    strobe(1'b1, 2);
    check("gap2_code", int'(code_o), 'b0110010);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/symbol_rx.md
SYMBOL_RX -- requirements
Module: symbol_rx

Interface
REQ-001 Parameter DATA_W, default 7: symbol payload width in bits.
REQ-002 Parameter ERR_W, default 4: width of the saturating error counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_i  input  1  serial line, idle high, already synchronous to clk.
REQ-006 bit_en_i  input  1  one-cycle strobe marking a bit-sample instant; rx_i is sampled only when it is high.
REQ-007 clr_err_i  input  1  synchronous clear of err_cnt_o.
REQ-008 code_o  output  DATA_W  last accepted symbol, MSB first on the line, held between frames.
REQ-009 code_valid_o  output  1  one-cycle pulse; code_o is new in that cycle; drives the sequence checker's valid strobe.
REQ-010 parity_err_o  output  1  one-cycle pulse on a parity failure.
REQ-011 frame_err_o  output  1  one-cycle pulse on a missing stop bit.
REQ-012 err_cnt_o  output  ERR_W  count of parity and framing errors.

Function
REQ-013 The FSM SHALL have the states IDLE, DATA, PARITY, STOP and BREAK, and SHALL advance only in cycles where bit_en_i=1.
REQ-014 IDLE: rx_i=0 SHALL go to DATA with the bit counter at 0; rx_i=1 SHALL stay in IDLE.
REQ-015 DATA: each strobe SHALL shift rx_i into the shift register MSB first; after the DATA_W-th bit the FSM SHALL go to PARITY, or to STOP when parity is compiled out.
REQ-016 PARITY: odd parity; the SHALL latch parity_ok=1 when the payload plus the parity bit hold an odd number of ones, then go to STOP.
REQ-017 STOP with rx_i=1 and parity_ok=1: code_o SHALL load and code_valid_o SHALL pulse on the next clock edge (1-cycle latency from the stop strobe), then IDLE.
REQ-018 STOP with rx_i=1 and parity_ok=0: parity_err_o SHALL pulse, code_o SHALL be unchanged, then IDLE.
REQ-019 STOP with rx_i=0: frame_err_o SHALL pulse, code_o SHALL be unchanged, then BREAK; when parity also failed, only frame_err_o SHALL pulse.
REQ-020 BREAK SHALL return to IDLE on the first strobe that samples rx_i=1, and SHALL NOT treat any sample as a start bit.
REQ-021 code_valid_o, parity_err_o and frame_err_o SHALL be mutually exclusive and never wider than one cycle.
REQ-022 err_cnt_o SHALL increment by 1 per error pulse and saturate at 2^ERR_W-1 (15 by default), with no wrap.
REQ-023 When clr_err_i and an error pulse occur in the same cycle, clear SHALL win and err_cnt_o SHALL be 0.
REQ-024 bit_en_i low SHALL freeze all FSM and shift state; rx_i changes between strobes SHALL be ignored.

Reset
REQ-025 When reset=0, the block SHALL asynchronously force state IDLE, bit counter 0, shift register 0, and parity_ok 0.
REQ-026 When reset=0, the block SHALL also force code_o=0, code_valid_o=0, parity_err_o=0, frame_err_o=0 and err_cnt_o=0.
REQ-027 A reset mid-frame SHALL discard the partial symbol; the next start bit after release SHALL begin a fresh frame.

Configuration
REQ-028 With SYMBOL_RX_PARITY_EN defined, the frame SHALL be start + DATA_W data bits + parity + stop, and REQ-016/REQ-018 SHALL apply.
REQ-029 Without SYMBOL_RX_PARITY_EN, the frame SHALL be start + DATA_W data bits + stop, the PARITY state SHALL be absent, and parity_err_o SHALL be tied to 0.

Structure
REQ-030 Package symbol_rx_pkg SHALL hold the FSM state enum, the frame-bit-count constants (with and without parity) and the parity-polarity constant.
REQ-031 The sub-module sat_counter (ERR_W-bit, inc/clr, clear priority) SHALL implement err_cnt_o; all else is in symbol_rx.

Verification
REQ-032 Payload 1011000 with p=0 and a good stop -> code_o=1011000 and code_valid_o high for exactly 1 cycle, 1 clk after the stop strobe.
REQ-033 Payload 0101000 with p=0 (bad parity) -> parity_err_o pulse, code_o keeps its previous value, err_cnt_o 0->1.
REQ-034 Payload 1101011 with the stop bit =0, then rx held low for 3 strobes, then a 0001100 frame -> frame_err_o once; no start is taken while low; 0001100 is accepted after the line goes high.
REQ-035 17 consecutive framing errors -> err_cnt_o=15 (saturated); clr_err_i together with an 18th error -> err_cnt_o=0.
REQ-036 reset asserted after the 4th data bit of 0110010, then a full good 0100011 frame -> no pulse for the aborted frame, code_o=0100011.
REQ-037 bit_en_i gaps of 0-5 idle cycles with rx_i toggling between strobes -> the same results as REQ-032; build both with and without SYMBOL_RX_PARITY_EN.
